// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: data width, op codes,
// FSM state encoding and the legal-op helper.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;

    // ALU op codes
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd15;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // True for the op codes the ALU implements.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR) ||
               (op == OP_PASS);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the ALU arbiter. The master side holds the two
// requesters and the response consumer; the slave side is the arbiter.
interface alu_arbiter_if;

    logic                              req0_valid;
    logic                              req0_ready;
    logic [3:0]                        req0_op;
    logic [alu_arbiter_pkg::DATA_W-1:0] req0_a;
    logic [alu_arbiter_pkg::DATA_W-1:0] req0_b;

    logic                              req1_valid;
    logic                              req1_ready;
    logic [3:0]                        req1_op;
    logic [alu_arbiter_pkg::DATA_W-1:0] req1_a;
    logic [alu_arbiter_pkg::DATA_W-1:0] req1_b;

    logic                              rsp_valid;
    logic                              rsp_ready;
    logic                              rsp_id;
    logic [alu_arbiter_pkg::DATA_W-1:0] rsp_result;
    logic                              rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Datapath ALU shared by both requesters. Purely combinational; op codes it
// does not implement produce zero, legality is judged by the arbiter.
module Alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = alu_arbiter_pkg::DATA_W
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);

    // Select the operation result for the current op code
    always_comb begin
        // NOTE: default first so every path assigns o_result and no latch is inferred.
        o_result = '0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_PASS: o_result = i_a;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU. One operation
// is in flight at a time: IDLE accepts, EXEC computes, RESP holds the result
// until the consumer takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = alu_arbiter_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    alu_arbiter_if.slave       bus,
    output logic               busy
);

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_id;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_err;

    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu_result;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        w_grant_valid = bus.req0_valid | bus.req1_valid;
        w_grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (bus.req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    // Accept only in IDLE and never while reset is applied
    assign w_accept       = !rst && (r_state == ST_IDLE) && w_grant_valid;
    assign bus.req0_ready = w_accept && !w_grant_id;
    assign bus.req1_ready = w_accept &&  w_grant_id;

    Alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result)
    );

    // Control FSM, grant pointer and response registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_EXEC;
                        r_last_grant <= w_grant_id;
                    end
                end
                ST_EXEC: begin
                    r_state      <= ST_RESP;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_result <= is_legal_op(r_op) ? w_alu_result : '0;
                    r_rsp_err    <= !is_legal_op(r_op);
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Capture the granted operation so later requester changes cannot disturb it
    always_ff @(posedge clk) begin
        // NOTE: operand latches carry no reset; they are only read after an accept has loaded them.
        if (w_accept) begin
            r_id <= w_grant_id;
            r_op <= w_grant_id ? bus.req1_op : bus.req0_op;
            r_a  <= w_grant_id ? bus.req1_a  : bus.req0_a;
            r_b  <= w_grant_id ? bus.req1_b  : bus.req0_b;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_err    = r_rsp_err;
    assign busy           = (r_state != ST_IDLE);

endmodule
